// File: rtl/mult_pkg.sv
// Shared definitions for the sequential arithmetic blocks.
// Holds the controller state encoding and the counter-width helper.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 1) ? v - 1 : 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_n.sv
// WIDTH-bit adder with carry in/out; the structure is left to synthesis.
// It is the parametrised form of the 8-bit prefix adder.
module add_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial product per clock, start/done handshake.
// Signed operands are multiplied as magnitudes and the sign is applied in FIX.
module seq_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] y
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = clog2(WIDTH);

  state_t           state;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [PW-1:0]    add_a;
  logic [PW-1:0]    add_b;
  logic             add_cin;
  logic [PW-1:0]    add_sum;
  logic             unused_cout;

  // The most-negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  assign abs_a = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign abs_b = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // One adder serves both the accumulate step and the final two's-complement negate.
  always_comb begin
    add_a   = acc;
    add_b   = mplier[0] ? mcand : '0;
    add_cin = 1'b0;
    if (state == FIX) begin
      add_a   = ~acc;
      add_b   = '0;
      add_cin = 1'b1;
    end
  end

  add_n #(
    .WIDTH(PW)
  ) u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .cout(unused_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= PW'(abs_a);
            mplier <= abs_b;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc    <= add_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          y     <= neg ? add_sum : acc;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=8 (directed) and WIDTH=4/16 (random).
// Drivers queue expected products; per-instance monitors check y and latency on done.
module tb_seq_mult;

  typedef struct {
    longint unsigned y;
    longint          cyc;
  } exp_t;

  logic clk;
  logic rst8, rst_o;
  longint cyc;
  int n_checks, n_fail;

  logic        st8, sg8, bz8, dn8;
  logic [7:0]  a8, b8;
  logic [15:0] y8;
  logic        st4, sg4, bz4, dn4;
  logic [3:0]  a4, b4;
  logic [7:0]  y4;
  logic        st16, sg16, bz16, dn16;
  logic [15:0] a16, b16;
  logic [31:0] y16;

  exp_t q8[$];
  exp_t q4[$];
  exp_t q16[$];

  seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .start(st8), .is_signed(sg8), .a(a8), .b(b8),
    .busy(bz8), .done(dn8), .y(y8));
  seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(rst_o), .start(st4), .is_signed(sg4), .a(a4), .b(b4),
    .busy(bz4), .done(dn4), .y(y4));
  seq_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(rst_o), .start(st16), .is_signed(sg16), .a(a16), .b(b16),
    .busy(bz16), .done(dn16), .y(y16));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint unsigned act, input longint unsigned req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  // Mathematical product of two w-bit operands, reduced to 2w bits.
  function automatic longint unsigned ref_mul(input int unsigned w, input bit sgn,
                                              input longint unsigned x, input longint unsigned z);
    longint sx, sz;
    longint unsigned m;
    sx = longint'(x);
    sz = longint'(z);
    if (sgn && ((x >> (w - 1)) & 1) == 1) sx = sx - (longint'(1) << w);
    if (sgn && ((z >> (w - 1)) & 1) == 1) sz = sz - (longint'(1) << w);
    m = (longint'(1) << (2 * w)) - 1;
    return longint'(sx * sz) & m;
  endfunction

  // Monitors: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (dn8) begin
      if (q8.size() == 0) check("w8 done without request", 1, 0);
      else begin
        e = q8.pop_front();
        check("w8 y", longint'(y8), e.y);
        check("w8 latency", longint'(cyc - e.cyc + 1), 10);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (dn4) begin
      if (q4.size() == 0) check("w4 done without request", 1, 0);
      else begin
        e = q4.pop_front();
        check("w4 y", longint'(y4), e.y);
        check("w4 latency", longint'(cyc - e.cyc + 1), 6);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (dn16) begin
      if (q16.size() == 0) check("w16 done without request", 1, 0);
      else begin
        e = q16.pop_front();
        check("w16 y", longint'(y16), e.y);
        check("w16 latency", longint'(cyc - e.cyc + 1), 18);
      end
    end
  end

  // Returns at the negedge just after the accepting clock edge.
  task automatic issue8(input logic [7:0] x, input logic [7:0] z, input logic s,
                        input longint unsigned req);
    int t;
    t = 0;
    @(negedge clk);
    while (bz8 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("w8 ready timeout", 1, 0);
    st8 = 1'b1; a8 = x; b8 = z; sg8 = s;
    q8.push_back('{req, cyc + 1});
    @(negedge clk);
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
  endtask

  task automatic wait_done8();
    int t;
    t = 0;
    while (!dn8 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("w8 done timeout", 1, 0);
  endtask

  task automatic run_w8();
    int nb, t, nd;
    // Unsigned 15x15 with busy-length and pulse-width checks.
    issue8(8'h0F, 8'h0F, 1'b0, 64'h00E1);
    nb = 0; t = 0;
    while (!dn8 && t < 40) begin
      if (bz8) nb++;
      @(negedge clk);
      t++;
    end
    check("w8 busy cycles", longint'(nb), 9);
    @(negedge clk);
    check("w8 done pulse width", longint'(dn8), 0);
    // Unsigned extremes and signed corners.
    issue8(8'hFF, 8'hFF, 1'b0, 64'hFE01); wait_done8();
    issue8(8'h00, 8'hFF, 1'b0, 64'h0000); wait_done8();
    issue8(8'h01, 8'hC8, 1'b0, 64'h00C8); wait_done8();
    issue8(8'hFD, 8'h05, 1'b1, 64'hFFF1); wait_done8();
    issue8(8'h80, 8'h80, 1'b1, 64'h4000); wait_done8();
    issue8(8'h80, 8'h7F, 1'b1, 64'hC080); wait_done8();
    issue8(8'hFF, 8'hFF, 1'b1, 64'h0001); wait_done8();
    // start while busy must be ignored.
    issue8(8'h0F, 8'h03, 1'b0, 64'h002D);
    @(negedge clk);
    st8 = 1'b1; a8 = 8'h55; b8 = 8'h66; sg8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    wait_done8();
    // Back-to-back start in the done cycle; old y held meanwhile.
    issue8(8'h02, 8'h03, 1'b0, 64'h0006);
    wait_done8();
    st8 = 1'b1; a8 = 8'h06; b8 = 8'h07; sg8 = 1'b0;
    q8.push_back('{64'h002A, cyc + 1});
    @(negedge clk);
    st8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("w8 y held during next op", longint'(y8), 64'h0006);
      @(negedge clk);
    end
    wait_done8();
    // Reset during the 4th CALC cycle aborts the operation.
    issue8(8'h0F, 8'h0F, 1'b0, 64'h00E1);
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    q8.delete();
    @(negedge clk);
    check("w8 busy after abort", longint'(bz8), 0);
    check("w8 done after abort", longint'(dn8), 0);
    check("w8 y after abort", longint'(y8), 0);
    rst8 = 1'b0;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (dn8) nd++;
    end
    check("w8 no done after abort", longint'(nd), 0);
    issue8(8'h03, 8'h03, 1'b0, 64'h0009); wait_done8();
  endtask

  task automatic run_rand4();
    int t;
    bit s;
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      t = 0;
      while (bz4 && t < 30) begin
        @(negedge clk);
        t++;
      end
      if (t >= 30) begin
        check("w4 ready timeout", 1, 0);
        break;
      end
      s = (i >= 1000);
      st4 = 1'b1; sg4 = s; a4 = 4'($urandom); b4 = 4'($urandom);
      q4.push_back('{ref_mul(4, s, longint'(a4), longint'(b4)), cyc + 1});
      @(negedge clk);
      st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sg4 = 1'($urandom);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
  endtask

  task automatic run_rand16();
    int t;
    bit s;
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      t = 0;
      while (bz16 && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (t >= 60) begin
        check("w16 ready timeout", 1, 0);
        break;
      end
      s = (i >= 1000);
      st16 = 1'b1; sg16 = s; a16 = 16'($urandom); b16 = 16'($urandom);
      q16.push_back('{ref_mul(16, s, longint'(a16), longint'(b16)), cyc + 1});
      @(negedge clk);
      st16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sg16 = 1'($urandom);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst8 = 1'b1; rst_o = 1'b1;
    st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    st4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
    st16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("w8 reset busy", longint'(bz8), 0);
    check("w8 reset done", longint'(dn8), 0);
    check("w8 reset y", longint'(y8), 0);
    check("w4 reset y", longint'(y4), 0);
    check("w16 reset y", longint'(y16), 0);
    rst8 = 1'b0; rst_o = 1'b0;
    fork
      run_w8();
      run_rand4();
      run_rand16();
    join
    repeat (30) @(negedge clk);
    check("w8 outstanding requests", longint'(q8.size()), 0);
    check("w4 outstanding requests", longint'(q4.size()), 0);
    check("w16 outstanding requests", longint'(q16.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog expired");
  end

endmodule
